// File: rtl/apb_mem_pkg.sv
// apb_mem_pkg
//   Shared definitions for the APB memory arbiter: FSM state encoding,
//   default bus widths, and width helpers for the arbiter pointer and the
//   ACCESS timeout counter.
package apb_mem_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // Width of a requester index / round-robin pointer.
    function automatic int idx_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Width of the ACCESS timeout counter; it only ever holds TIMEOUT-1.
    function automatic int tmo_cnt_w(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/apb_mem_arbiter_rr.sv
// rr_arbiter
//   Combinational round-robin pick. Searches the request vector starting at
//   ptr and wrapping; the first requester found wins.
// Ports
//   req      in   NUM_REQ   request vector
//   ptr      in   IDX_W     index with highest priority this round
//   gnt      out  NUM_REQ   one-hot grant (0 when no request)
//   gnt_idx  out  IDX_W     index of the granted requester
//   any_req  out  1         at least one request present
module rr_arbiter
    import apb_mem_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any_req
);

    int cand;

    // Walk from the lowest to the highest priority so that the last hit,
    // which overwrites earlier ones, is the requester closest to ptr.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = 0;
        any_req = |req;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/apb_mem_arbiter.sv
// apb_mem_arbiter
//   Shares one APB memory slave between NUM_REQ local requesters. Grants
//   round-robin, runs the APB SETUP/ACCESS handshake, returns read data and
//   error with a one-cycle done pulse, and aborts a transfer whose slave
//   does not answer within TIMEOUT ACCESS cycles. All outputs registered.
// Ports
//   pclk_i     in   1               clock, rising edge
//   presetn_i  in   1               async active-low reset
//   req_i      in   NUM_REQ         per-requester request, held until done_o
//   wr_i       in   NUM_REQ         1=write 0=read
//   addr_i     in   NUM_REQ*ADDR_W  packed addresses
//   wdata_i    in   NUM_REQ*DATA_W  packed write data
//   done_o     out  NUM_REQ         one-hot completion pulse
//   rdata_o    out  DATA_W          read data, valid with done_o
//   err_o      out  1               slave error or timeout, valid with done_o
//   busy_o     out  1               transfer in progress
//   psel_o, penable_o, pwrite_o, paddr_o, pwdata_o   APB master outputs
//   prdata_i, pready_i, pslverr_i                    APB slave responses
//
// state  | meaning
// IDLE   | no transfer; arbitrate and latch the winner's fields
// SETUP  | APB setup phase, psel=1 penable=0
// ACCESS | APB access phase, wait for pready or timeout
// RESP   | done pulse to the winner with rdata/err
module apb_mem_arbiter
    import apb_mem_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                      pclk_i,
    input  logic                      presetn_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        wr_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        done_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      err_o,
    output logic                      busy_o,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic                      pwrite_o,
    output logic [ADDR_W-1:0]         paddr_o,
    output logic [DATA_W-1:0]         pwdata_o,
    input  logic [DATA_W-1:0]         prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int CNT_W = tmo_cnt_w(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT - 1);

    apb_state_e         state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   tmo_q;
    logic [NUM_REQ-1:0] gnt_q;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req     (req_i),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any_req (arb_any)
    );

    // The APB address/data/direction registers double as the latched copy
    // of the winner's request, so later changes on the requester side do
    // not disturb the transfer in flight.
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            tmo_q     <= '0;
            gnt_q     <= '0;
            done_o    <= '0;
            rdata_o   <= '0;
            err_o     <= 1'b0;
            busy_o    <= 1'b0;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            pwrite_o  <= 1'b0;
            paddr_o   <= '0;
            pwdata_o  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        gnt_q    <= arb_gnt;
                        ptr_q    <= (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
                        tmo_q    <= TMO_LOAD;
                        busy_o   <= 1'b1;
                        psel_o   <= 1'b1;
                        pwrite_o <= wr_i[arb_idx];
                        paddr_o  <= addr_i[arb_idx*ADDR_W +: ADDR_W];
                        pwdata_o <= wr_i[arb_idx] ? wdata_i[arb_idx*DATA_W +: DATA_W] : '0;
                        state_q  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_o <= 1'b1;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // pready wins over a timeout landing on the same edge.
                    if (pready_i || tmo_q == '0) begin
                        psel_o    <= 1'b0;
                        penable_o <= 1'b0;
                        pwrite_o  <= 1'b0;
                        paddr_o   <= '0;
                        pwdata_o  <= '0;
                        done_o    <= gnt_q;
                        state_q   <= ST_RESP;
                        if (pready_i) begin
                            rdata_o <= pwrite_o ? '0 : prdata_i;
                            err_o   <= pslverr_i;
                        end else begin
                            rdata_o <= '0;
                            err_o   <= 1'b1;
                        end
                    end else begin
                        tmo_q <= tmo_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    done_o  <= '0;
                    rdata_o <= '0;
                    err_o   <= 1'b0;
                    busy_o  <= 1'b0;
                    gnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_mem_arbiter.sv
// tb_apb_mem_arbiter
//   Directed cases followed by randomized traffic. A behavioural slave with
//   random wait states serves the APB side; a transaction-level model
//   (round-robin by distance from the pointer, reference memory) predicts
//   every grant, done pulse, read value and error.
module tb_apb_mem_arbiter;

    localparam int N   = 2;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int TMO = 16;

    typedef struct {
        bit          wr;
        bit [AW-1:0] addr;
        bit [DW-1:0] data;
    } xfer_t;

    logic            pclk_i_tb;
    logic            presetn_i_tb;
    logic [N-1:0]    req;
    logic [N-1:0]    wr;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    done;
    logic [DW-1:0]   rdata;
    logic            err;
    logic            busy;
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic [DW-1:0]   prdata;
    logic            pready;
    logic            pslverr;

    apb_mem_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .pclk_i    (pclk_i_tb),
        .presetn_i (presetn_i_tb),
        .req_i     (req),
        .wr_i      (wr),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .done_o    (done),
        .rdata_o   (rdata),
        .err_o     (err),
        .busy_o    (busy),
        .psel_o    (psel),
        .penable_o (penable),
        .pwrite_o  (pwrite),
        .paddr_o   (paddr),
        .pwdata_o  (pwdata),
        .prdata_i  (prdata),
        .pready_i  (pready),
        .pslverr_i (pslverr)
    );

    initial pclk_i_tb = 1'b0;
    always #5 pclk_i_tb = ~pclk_i_tb;

    int n_vec = 0;
    int n_err = 0;

    xfer_t       cur [N];
    xfer_t       hq  [N][$];
    bit          granted [N];
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    int          grants[$];

    int          outstanding = 0;
    int          ptr_m = 0;
    bit          have_exp = 0;
    int          exp_win = 0;
    xfer_t       snap;
    bit          snap_stall = 0;
    bit          stall = 0;
    int          max_wait = 0;
    int          wait_left = 0;
    int          wait_set = 0;
    int          acc_len = 0;
    bit          rand_mode = 0;
    bit          lat_chk = 0;
    bit          gap_chk = 0;
    int          cyc = 0;
    int          arm_cyc = 0;
    int          last_done_cyc = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    logic [N-1:0] last_done = '0;
    int          last_acc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic xfer_t mk(input bit w, input bit [AW-1:0] a, input bit [DW-1:0] d);
        xfer_t x;
        x.wr   = w;
        x.addr = a;
        x.data = d;
        return x;
    endfunction

    function automatic xfer_t rand_xfer();
        xfer_t x;
        x.wr   = 1'($urandom_range(0, 1));
        x.addr = 8'($urandom_range(0, 254));
        x.data = $urandom;
        if (!x.wr && $urandom_range(0, 15) == 0) x.addr = 8'hFF;
        return x;
    endfunction

    // Winner = pending requester with the smallest wrap-around distance
    // from the pointer.
    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        int best  = -1;
        int bestd = N;
        for (int c = 0; c < N; c++) begin
            if (r[c] && ((c - p + N) % N) < bestd) begin
                bestd = (c - p + N) % N;
                best  = c;
            end
        end
        return best;
    endfunction

    task automatic apply_fields(input int n);
        wr[n]            = cur[n].wr;
        addr[n*AW +: AW] = cur[n].addr;
        wdata[n*DW +: DW] = cur[n].data;
    endtask

    task automatic arm(input int n, input xfer_t x);
        cur[n] = x;
        apply_fields(n);
        req[n]     = 1'b1;
        granted[n] = 1'b0;
        outstanding++;
        arm_cyc = cyc;
    endtask

    // One clock: sample at the falling edge, check, then drive the slave
    // response and requester changes for the next rising edge.
    task automatic step();
        logic [N-1:0] req_edge;
        logic [N-1:0] ed;
        logic [N-1:0] just_done;
        logic [31:0]  er;
        logic         ee;
        int           w;
        req_edge = req;
        @(negedge pclk_i_tb);
        cyc++;
        just_done = '0;
        if (rand_mode) stall = ($urandom_range(0, 24) == 0);

        if (done != '0) begin
            if (!have_exp) begin
                chk("done_spurious", done, '0);
            end else begin
                ed = '0;
                ed[exp_win] = 1'b1;
                er = snap_stall ? 32'd0 : (snap.wr ? 32'd0 : ref_mem[snap.addr]);
                ee = snap_stall ? 1'b1 : (snap.addr == 8'hFF);
                chk("done_onehot", done, ed);
                chk("rdata", rdata, er);
                chk("err", err, ee);
                chk("access_len", acc_len, snap_stall ? TMO : wait_set + 1);
                if (lat_chk) chk("latency", cyc - arm_cyc, 3);
                if (gap_chk && last_done_cyc > 0) chk("b2b_gap", cyc - last_done_cyc, 4);
                last_done_cyc = cyc;
                if (snap.wr && !snap_stall) ref_mem[snap.addr] = snap.data;
                last_rdata = rdata;
                last_err   = err;
                last_done  = done;
                last_acc   = acc_len;
                granted[exp_win] = 1'b0;
                have_exp = 1'b0;
                outstanding--;
                just_done[exp_win] = 1'b1;
                if (hq[exp_win].size() > 0) begin
                    cur[exp_win] = hq[exp_win].pop_front();
                    apply_fields(exp_win);
                    outstanding++;
                end else begin
                    req[exp_win] = 1'b0;
                end
            end
        end

        if (psel && !penable) begin
            w = rr_pick(req_edge, ptr_m);
            if (w < 0) begin
                chk("grant_without_req", (req_edge != '0), 1'b1);
            end else begin
                exp_win    = w;
                snap       = cur[w];
                snap_stall = stall;
                have_exp   = 1'b1;
                granted[w] = 1'b1;
                ptr_m      = (w + 1) % N;
                grants.push_back(w);
                chk("setup_paddr", paddr, snap.addr);
                chk("setup_pwrite", pwrite, snap.wr);
                chk("setup_pwdata", pwdata, snap.wr ? snap.data : 32'd0);
                if (rand_mode && $urandom_range(0, 3) == 0) begin
                    cur[w] = rand_xfer();
                    apply_fields(w);
                end
                if (rand_mode && $urandom_range(0, 3) == 0) req[w] = 1'b0;
            end
            acc_len   = 0;
            wait_left = stall ? 1000000 : $urandom_range(0, max_wait);
            wait_set  = wait_left;
        end

        pready  = 1'b0;
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
        if (psel && penable) begin
            acc_len++;
            if (have_exp) chk("access_paddr", paddr, snap.addr);
            if (wait_left == 0) begin
                pready  = 1'b1;
                prdata  = mem[paddr];
                pslverr = (paddr == 8'hFF);
                if (pwrite) mem[paddr] = pwdata;
            end else begin
                wait_left--;
            end
        end

        if (rand_mode) begin
            for (int n = 0; n < N; n++) begin
                if (!req[n] && !granted[n] && !just_done[n]) begin
                    if ($urandom_range(0, 2) == 0) arm(n, rand_xfer());
                end else if (req[n] && !granted[n] && $urandom_range(0, 19) == 0) begin
                    req[n] = 1'b0;
                    outstanding--;
                end
            end
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int k = 0;
        while ((outstanding != 0 || have_exp) && k < budget) begin
            step();
            k++;
        end
        chk(tag, outstanding, 0);
        step();
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom | 32'h1;
            ref_mem[i] = mem[i];
        end
        for (int n = 0; n < N; n++) granted[n] = 1'b0;
        presetn_i_tb = 1'b0;
        req     = '0;
        wr      = '0;
        addr    = '0;
        wdata   = '0;
        prdata  = '0;
        pready  = 1'b0;
        pslverr = 1'b0;

        step();
        step();
        chk("rst_psel", psel, 1'b0);
        chk("rst_penable", penable, 1'b0);
        chk("rst_done", done, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rdata_err", {rdata, err}, '0);
        chk("rst_apb_bus", {pwrite, paddr, pwdata}, '0);
        presetn_i_tb = 1'b1;
        step();

        // 1: zero-wait write from requester 0
        lat_chk = 1'b1;
        arm(0, mk(1'b1, 8'h01, 32'd15));
        step();
        chk("t1_setup_psel", psel, 1'b1);
        chk("t1_setup_penable", penable, 1'b0);
        chk("t1_setup_busy", busy, 1'b1);
        step();
        chk("t1_access_penable", penable, 1'b1);
        step();
        chk("t1_done", done, 2'b01);
        chk("t1_err", err, 1'b0);
        chk("t1_resp_busy", busy, 1'b1);
        chk("t1_resp_psel", psel, 1'b0);
        step();
        chk("t1_done_clear", done, '0);
        chk("t1_idle_busy", busy, 1'b0);
        chk("t1_mem", mem[1], 32'd15);
        lat_chk = 1'b0;

        // 2: requester 1 reads it back
        arm(1, mk(1'b0, 8'h01, 32'hDEAD_BEEF));
        drain("t2_drain", 20);
        chk("t2_done", last_done, 2'b10);
        chk("t2_rdata", last_rdata, 32'd15);

        // 3: both held for four transfers
        grants.delete();
        gap_chk       = 1'b1;
        last_done_cyc = 0;
        hq[0].push_back(mk(1'b0, 8'h10, 32'd0));
        hq[1].push_back(mk(1'b1, 8'h20, 32'h1234_5678));
        arm(0, mk(1'b1, 8'h10, 32'hCAFE_0010));
        arm(1, mk(1'b0, 8'h01, 32'd0));
        drain("t3_drain", 40);
        gap_chk = 1'b0;
        chk("t3_count", grants.size(), 4);
        for (int i = 0; i < grants.size() && i < 4; i++) chk("t3_order", grants[i], i % 2);
        chk("t3_mem20", mem[8'h20], 32'h1234_5678);

        // 4: slave never ready -> timeout
        stall = 1'b1;
        arm(0, mk(1'b0, 8'h05, 32'd0));
        drain("t4_drain", 40);
        stall = 1'b0;
        chk("t4_err", last_err, 1'b1);
        chk("t4_rdata", last_rdata, 32'd0);
        chk("t4_access_len", last_acc, TMO);
        chk("t4_psel_after", psel, 1'b0);

        // 5: slave error on address FF
        arm(1, mk(1'b0, 8'hFF, 32'd0));
        drain("t5_drain", 20);
        chk("t5_done", last_done, 2'b10);
        chk("t5_err", last_err, 1'b1);

        // 6: reset during ACCESS, then pointer restarts at 0
        stall = 1'b1;
        arm(0, mk(1'b0, 8'h07, 32'd0));
        for (int k = 0; k < 12 && !(psel && penable && acc_len >= 3); k++) step();
        chk("t6_in_access", psel && penable, 1'b1);
        #2;
        presetn_i_tb = 1'b0;
        #1;
        chk("t6_rst_psel", psel, 1'b0);
        chk("t6_rst_penable", penable, 1'b0);
        chk("t6_rst_done", done, '0);
        chk("t6_rst_busy", busy, 1'b0);
        have_exp    = 1'b0;
        outstanding = 0;
        ptr_m       = 0;
        stall       = 1'b0;
        req         = '0;
        for (int n = 0; n < N; n++) granted[n] = 1'b0;
        step();
        step();
        presetn_i_tb = 1'b1;
        grants.delete();
        arm(0, mk(1'b1, 8'h30, 32'h0BAD_F00D));
        arm(1, mk(1'b0, 8'h01, 32'd0));
        drain("t6_drain", 40);
        chk("t6_count", grants.size(), 2);
        if (grants.size() > 0) chk("t6_first_grant", grants[0], 0);

        // 7: randomized traffic with waits, timeouts, withdrawals and
        // field changes after grant
        max_wait  = 3;
        rand_mode = 1'b1;
        for (int k = 0; k < 2500; k++) step();
        rand_mode = 1'b0;
        stall     = 1'b0;
        drain("t7_drain", 300);
        chk("t7_idle_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
